// File: rtl/mem_responder.sv
// Word-addressed valid/ready memory target with a fixed number of wait states.
// Define MEM_RESPONDER_JITTER_EN to add 0..3 pseudo-random extra wait states per request.
module mem_responder #(
  parameter int DEPTH = 10,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata
);

`ifdef MEM_RESPONDER_JITTER_EN
  localparam int CW = 10;
`else
  localparam int CW = 8;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, load_cnt;
  logic [DEPTH-1:0] idx_q, idx;
  logic [31:0]      wdata_q, wdata;
  logic [3:0]       wstrb_q, wstrb;
  logic             accept, enter_resp;
  logic [31:0]      mem [2**DEPTH];

  // Byte-offset and aliased upper address bits carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:DEPTH+2], mem_addr[1:0]};

`ifdef MEM_RESPONDER_JITTER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign load_cnt = CW'(WAIT) + CW'(lfsr[1:0]);
`else
  assign load_cnt = CW'(WAIT);
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          accept  = 1'b1;
          cnt_nxt = load_cnt;
          if (load_cnt == '0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // With zero wait states the response edge is also the accept edge, so use live inputs then.
  assign idx   = accept ? mem_addr[DEPTH+1:2] : idx_q;
  assign wdata = accept ? mem_wdata : wdata_q;
  assign wstrb = accept ? mem_wstrb : wstrb_q;

  assign mem_ready = (state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q   <= mem_addr[DEPTH+1:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (enter_resp) mem_rdata <= mem[idx];
    end
  end

  // Array has no reset; the read above sees the pre-write word on the same edge.
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed memory responder for the valid/ready memory bus driven by the instruction cache and other bus initiators. Accepts one request at a time, inserts a configurable number of wait states, then returns read data or performs a byte-masked write and pulses `mem_ready` for one cycle. It is the target end of the cache `mem_*` port, used as program/data RAM in simulation and small FPGA builds.

## Interface
- `DEPTH`, 10, log2 of the number of 32-bit words in the array.
- `WAIT`, 2, fixed wait states between accept and response, 0..255.
- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_valid`  in  1  request valid; the initiator holds it high until `mem_ready`.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_addr`  in  32  byte address; bits [1:0] are ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; all zero means read.
- `mem_rdata`  out  32  read data, valid while `mem_ready` is high.

## Operation
- Word index is `mem_addr[DEPTH+1:2]`. Upper address bits are ignored, so addresses alias modulo 4·2^DEPTH bytes.
- FSM states:
  - IDLE: if `mem_valid`, latch addr/wdata/wstrb, load the wait counter with `WAIT` (plus jitter, see Configuration), then go to WAIT, or to RESP if the loaded count is 0.
  - WAIT: decrement the counter; at 1, go to RESP.
  - RESP: `mem_ready`=1 for exactly this cycle, then go to IDLE.
- Data path on the edge entering RESP:
  - `mem_rdata` is loaded with the stored word as it was before any write.
  - For each set `wstrb[i]`, byte i of the array is written with `wdata[8i+7:8i]`.
  - A write therefore returns the old word on `mem_rdata`.
- The request is latched at accept. Changes to `mem_addr`/`mem_wdata`/`mem_wstrb`, or `mem_valid` dropping mid-request (a protocol violation), do not alter or abort the transaction. The completion pulse still occurs.
- `mem_valid` is ignored in WAIT and RESP. It is next sampled in IDLE, the cycle after the ready pulse. A still-high `mem_valid` in that IDLE cycle is a new request, so back-to-back transfers are allowed.
- `mem_rdata` holds its last value between responses.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, FSM=IDLE, counter=0. Array contents are not reset.
- Latency: with `mem_valid` sampled high in IDLE at edge E, `mem_ready` is high in the cycle after edge E+WAIT. That is WAIT+1 cycles after accept.
- Throughput: one transfer per WAIT+2 cycles with `mem_valid` held continuously (accept, WAIT cycles, RESP).
- Reset asserted mid-request:
  - FSM returns to IDLE and `mem_ready` goes to 0 immediately.
  - No write is performed unless the RESP-entry edge has already occurred.
- Counter width is 8 bits, plus 2 bits of jitter headroom when enabled. There is no wrap.

## Configuration
- `MEM_RESPONDER_JITTER_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle.
  - At accept, its low 2 bits (0..3) are added to `WAIT`.
  - Latency becomes WAIT+1..WAIT+4, for initiator stress testing.
- Undefined: the LFSR is absent and latency is exactly WAIT+1.

## Test plan
- Reset, then read address 0x0 with WAIT=2 -> `mem_ready` 3 cycles after accept; `mem_rdata` equals the preloaded word; `mem_ready` stays 0 during reset.
- Write 0xDEADBEEF with wstrb=4'hF to 0x40, then read 0x40 -> the read returns 0xDEADBEEF; the write response returns the prior word.
- Write 0x000000AA with wstrb=4'b0001 over 0x11223344 -> a read returns 0x112233AA.
- WAIT=0, `mem_valid` held high for 4 reads -> ready pulses every 2nd cycle; 4 pulses in 8 cycles.
- Assert `rst` during WAIT of a write -> `mem_ready` 0, word unchanged on re-read, next request completes normally.
- DEPTH=4, write to 0x44, read 0x04 -> same data (aliasing). With `MEM_RESPONDER_JITTER_EN` defined, WAIT=2 -> every observed latency lies in 3..6.
